jtag_bb_sched: RTL and testbench

Arbiter and sequencer for the JTAG bit banger. Two requesters share one bit-banger: the host register path and the hardware auto-trigger. The block grants the bit-banger round-robin and presents the winner's pattern. It pulses the bit-banger's go, tracks its busy/done handshake, and returns a per-requester acknowledge. An optional watchdog recovers a hung sequence. It sits between the register file / trigger logic and jtag_bit_banger.

---
 rtl/jtag_bb_sched.sv | 142 ++++++++++++++
 tb/tb_jtag_bb_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_bb_sched.sv
// Round-robin arbiter and launch sequencer sharing one JTAG bit-banger between host and trigger.
// Optional watchdog abort enabled by defining JTAG_SCHED_TIMEOUT_EN.
module jtag_bb_sched #(
  parameter int pPATTERN_WIDTH = 16,
  parameter int pGAP           = 8,
  parameter int pTIMEOUT_W     = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req,
  input  logic [pPATTERN_WIDTH-1:0] pattern0,
  input  logic [pPATTERN_WIDTH-1:0] pattern1,
  output logic [1:0]                ack,
  output logic [1:0]                grant,
  output logic                      err,
  input  logic                      err_clr,
  output logic [pPATTERN_WIDTH-1:0] bb_pattern,
  output logic                      bb_go,
  output logic                      bb_reset,
  input  logic                      bb_busy,
  input  logic                      bb_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_GAP, S_ABORT
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_owner, w_owner_nxt;   // 0 = host, 1 = trigger
  logic                      r_last, w_last_nxt;
  logic [1:0]                r_grant, w_grant_nxt;
  logic [1:0]                r_ack, w_ack_nxt;
  logic [pPATTERN_WIDTH-1:0] r_pattern, w_pattern_nxt;
  logic                      r_go, w_go_nxt;
  logic                      r_bbrst, w_bbrst_nxt;
  logic                      r_err, w_err_set;
  logic [7:0]                r_gap;
  logic                      w_gap_done;
  logic                      w_wd_fire;
  logic                      w_unused_busy;

  assign w_unused_busy = bb_busy;
  assign w_gap_done    = (r_gap == 8'(pGAP));

`ifdef JTAG_SCHED_TIMEOUT_EN
  localparam logic [pTIMEOUT_W-1:0] WD_LAST = {{(pTIMEOUT_W-1){1'b1}}, 1'b0};
  logic [pTIMEOUT_W-1:0] r_wd;

  // Counter is zeroed as LAUNCH is entered and counts through LAUNCH and RUN;
  // abort is registered on the edge where it reaches all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      r_wd <= '0;
    else if (r_state == S_LOAD)
      r_wd <= '0;
    else if ((r_state == S_LAUNCH || r_state == S_RUN) && r_wd != '1)
      r_wd <= r_wd + 1'b1;
  end

  assign w_wd_fire = (r_state == S_RUN) && (r_wd == WD_LAST);
`else
  assign w_wd_fire = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = '0;
    w_pattern_nxt = r_pattern;
    w_go_nxt      = 1'b0;
    w_bbrst_nxt   = 1'b0;
    w_err_set     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_owner_nxt = (req == 2'b11) ? ~r_last : req[1];
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_pattern_nxt = r_owner ? pattern1 : pattern0;
        w_grant_nxt   = r_owner ? 2'b10 : 2'b01;
        w_go_nxt      = 1'b1;
        w_state_nxt   = S_LAUNCH;
      end
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN: begin
        if (bb_done) begin
          w_ack_nxt   = r_grant;
          w_last_nxt  = r_owner;
          w_grant_nxt = '0;
          w_state_nxt = S_GAP;
        end else if (w_wd_fire) begin
          w_ack_nxt   = r_grant;
          w_bbrst_nxt = 1'b1;
          w_err_set   = 1'b1;
          w_grant_nxt = '0;
          w_state_nxt = S_ABORT;
        end
      end
      S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_GAP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_grant   <= '0;
      r_ack     <= '0;
      r_pattern <= '0;
      r_go      <= 1'b0;
      r_bbrst   <= 1'b0;
      r_err     <= 1'b0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_pattern <= w_pattern_nxt;
      r_go      <= w_go_nxt;
      r_bbrst   <= w_bbrst_nxt;
      r_err     <= w_err_set | (r_err & ~err_clr);
      r_gap     <= (r_state == S_GAP) ? r_gap + 8'd1 : '0;
    end
  end

  assign ack        = r_ack;
  assign grant      = r_grant;
  assign err        = r_err;
  assign bb_pattern = r_pattern;
  assign bb_go      = r_go;
  assign bb_reset   = r_bbrst;

endmodule

// File: tb/tb_jtag_bb_sched.sv
// Scoreboard bench for jtag_bb_sched with a behavioural bit-banger model.
module tb_jtag_bb_sched;

  localparam int PW   = 16;
  localparam int PGAP = 8;
`ifdef JTAG_SCHED_TIMEOUT_EN
  localparam int TW  = 4;
  localparam int LAT = 8;
`else
  localparam int TW  = 24;
  localparam int LAT = 200;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [PW-1:0] pattern0, pattern1;
  logic [1:0]    ack, grant;
  logic          err, err_clr;
  logic [PW-1:0] bb_pattern;
  logic          bb_go, bb_reset;
  logic          bb_busy = 1'b0;
  logic          bb_done = 1'b0;

  jtag_bb_sched #(.pPATTERN_WIDTH(PW), .pGAP(PGAP), .pTIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .pattern0(pattern0), .pattern1(pattern1),
    .ack(ack), .grant(grant), .err(err), .err_clr(err_clr), .bb_pattern(bb_pattern),
    .bb_go(bb_go), .bb_reset(bb_reset), .bb_busy(bb_busy), .bb_done(bb_done)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] g; logic [PW-1:0] p;} go_t;
  go_t        exp_go[$];
  logic [1:0] exp_ack[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = -1;
  int go_cyc = 0;
  int bb_cnt = 0;
  logic          done_en = 1'b1;
  logic [PW-1:0] cur_pat = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard first, then bit-banger model, all on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      last_ack_cyc = -1;
      bb_busy = 1'b0;
      bb_done = 1'b0;
      bb_cnt  = 0;
    end else begin
      if (ack != 2'b00) begin
        if (exp_ack.size() == 0) check("ack_unexpected", {30'd0, ack}, 32'd0);
        else begin
          check("ack", {30'd0, ack}, {30'd0, exp_ack.pop_front()});
          check("ack_pattern", {16'd0, bb_pattern}, {16'd0, cur_pat});
          if (!bb_reset) check("ack_latency", {31'd0, bb_done}, 32'd1);
`ifndef JTAG_SCHED_TIMEOUT_EN
          check("no_abort", {30'd0, err, bb_reset}, 32'd0);
`endif
        end
        last_ack_cyc = cyc;
      end
      if (bb_go) begin
        if (exp_go.size() == 0) check("go_unexpected", 32'd1, 32'd0);
        else begin
          go_t e;
          e = exp_go.pop_front();
          check("go_grant", {30'd0, grant}, {30'd0, e.g});
          check("go_pattern", {16'd0, bb_pattern}, {16'd0, e.p});
          cur_pat = e.p;
          if (last_ack_cyc >= 0)
            check("gap_min", {31'd0, (cyc - last_ack_cyc) >= PGAP + 3}, 32'd1);
        end
        go_cyc = cyc;
      end
      if (grant != 2'b00 && bb_pattern !== cur_pat)
        check("pattern_hold", {16'd0, bb_pattern}, {16'd0, cur_pat});
      if (bb_reset) check("wd_latency", cyc - go_cyc, 32'd15);

      bb_done = 1'b0;
      if (bb_reset) bb_busy = 1'b0;
      else if (bb_go) begin
        bb_busy = 1'b1;
        bb_cnt  = LAT;
      end else if (bb_busy) begin
        bb_cnt--;
        if (bb_cnt <= 0 && done_en) begin
          bb_done = 1'b1;
          bb_busy = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [1:0] g, input logic [PW-1:0] p);
    go_t e;
    e.g = g;
    e.p = p;
    exp_go.push_back(e);
    exp_ack.push_back(g);
  endtask

  task automatic wait_ack();
    int n = 0;
    @(negedge clk);
    while (ack == 2'b00 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ack == 2'b00) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_go();
    int n = 0;
    @(negedge clk);
    while (!bb_go && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bb_go) check("go_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_go", {31'd0, bb_go}, 32'd0);
    check("rst_bbreset", {31'd0, bb_reset}, 32'd0);
    check("rst_pattern", {16'd0, bb_pattern}, 32'd0);
    exp_go.delete();
    exp_ack.delete();
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    req = 2'b00; pattern0 = '0; pattern1 = '0; err_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Tie from reset: host, trigger, host.
    pattern0 = 16'h1111;
    pattern1 = 16'h2222;
    push(2'b01, 16'h1111);
    push(2'b10, 16'h2222);
    push(2'b01, 16'h1111);
    req = 2'b11;
    repeat (3) wait_ack();
    req = 2'b00;
    repeat (PGAP + 10) @(negedge clk);

    // Host only with launch timing and pattern change after go.
    pattern0 = 16'hE73C;
    push(2'b01, 16'hE73C);
    req = 2'b01;
    @(negedge clk);
    check("go_early", {31'd0, bb_go}, 32'd0);
    @(negedge clk);
    check("go_latency", {31'd0, bb_go}, 32'd1);
    check("grant_latency", {30'd0, grant}, 32'd1);
    @(negedge clk);
    pattern0 = 16'h0000;
    check("go_one_cycle", {31'd0, bb_go}, 32'd0);
    wait_ack();
    req = 2'b00;
    repeat (PGAP + 10) @(negedge clk);

    // Trigger drops req after grant.
    pattern1 = 16'hABCD;
    push(2'b10, 16'hABCD);
    req = 2'b10;
    wait_go();
    @(negedge clk);
    req = 2'b00;
    wait_ack();
    repeat (2 * PGAP + 10) @(negedge clk);

    // Reset during RUN, then a normal relaunch.
    pattern0 = 16'h5A5A;
    push(2'b01, 16'h5A5A);
    req = 2'b01;
    wait_go();
    repeat (4) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    pattern0 = 16'h1234;
    push(2'b01, 16'h1234);
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    repeat (PGAP + 10) @(negedge clk);

`ifdef JTAG_SCHED_TIMEOUT_EN
    // Hung bit-banger: watchdog abort and err handling.
    done_en = 1'b0;
    pattern0 = 16'h0F0F;
    push(2'b01, 16'h0F0F);
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    check("abort_bbreset", {31'd0, bb_reset}, 32'd1);
    @(negedge clk);
    check("err_set", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", {31'd0, err}, 32'd0);
    repeat (5) @(negedge clk);
    check("err_stays_clear", {31'd0, err}, 32'd0);
    done_en = 1'b1;
    repeat (PGAP + 10) @(negedge clk);
`endif

    check("go_queue_empty", exp_go.size(), 32'd0);
    check("ack_queue_empty", exp_ack.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
